// File: rtl/sobel_pkg.sv
// Shared widths and the 3x3 Sobel gradient-magnitude kernel for the stream filter.
package sobel_pkg;

  localparam int PIX_W_MAX = 12;
  localparam int GRAD_OFS  = 3;
  localparam int GRAD_W_MAX = PIX_W_MAX + GRAD_OFS;

  typedef logic [PIX_W_MAX-1:0]       pix_t;
  typedef logic [GRAD_W_MAX-1:0]      mag_t;
  typedef logic [8:0][PIX_W_MAX-1:0]  win_t;  // [0]=top-left .. [8]=bottom-right

  function automatic int grad_w(input int pix_w);
    return pix_w + GRAD_OFS;
  endfunction

  // |gx|+|gy| of an 8-neighbour window; fits GRAD_W bits unsigned for any PIX_W.
  function automatic mag_t sobel_mag(input win_t p);
    int gx;
    int gy;
    gx = (int'(p[2]) - int'(p[0])) + 2 * (int'(p[5]) - int'(p[3])) + (int'(p[8]) - int'(p[6]));
    gy = (int'(p[0]) - int'(p[6])) + 2 * (int'(p[1]) - int'(p[7])) + (int'(p[2]) - int'(p[8]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return mag_t'(gx + gy);
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Valid/ready pixel stream in and filtered stream out.
interface sobel_stream_if #(parameter int PIX_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_sof;
  logic             out_eol;

  modport slave  (input  in_valid, in_pixel, in_sof, out_ready,
                  output in_ready, out_valid, out_pixel, out_sof, out_eol);
  modport master (output in_valid, in_pixel, in_sof, out_ready,
                  input  in_ready, out_valid, out_pixel, out_sof, out_eol);
endinterface

// File: rtl/sobel_linebuf.sv
// One image line of storage: async read, synchronous write, so a same-address
// read in the writing cycle returns the previous line's pixel.
module sobel_linebuf #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter: two line buffers plus a sliding window,
// one registered output per interior pixel, whole pipe stalls on backpressure.
module sobel_stream import sobel_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           thr_en,
  input  logic [PIX_W+2:0] thr,
  sobel_stream_if.slave  s
);
  localparam int GRAD_W = grad_w(PIX_W);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic              accept, interior;
  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic [PIX_W-1:0]  lb1_rd, lb2_rd;
  logic [1:0][PIX_W-1:0] top_q, mid_q, bot_q;  // [1]=col-1, [0]=col-2
  win_t              win;
  logic [GRAD_W-1:0] mag;
  logic [PIX_W-1:0]  res;
  logic              vld_q, vld_d, sof_q, sof_d, eol_q, eol_d;
  logic [PIX_W-1:0]  pix_q, pix_d;

  assign s.in_ready  = !vld_q || s.out_ready;
  assign accept      = s.in_valid && s.in_ready;
  assign cur_col     = s.in_sof ? '0 : col_q;
  assign cur_row     = s.in_sof ? '0 : row_q;
  assign interior    = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
    .clk(clk), .we_i(accept), .waddr_i(cur_col), .wdata_i(s.in_pixel),
    .raddr_i(cur_col), .rdata_o(lb1_rd));

  sobel_linebuf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb2 (
    .clk(clk), .we_i(accept), .waddr_i(cur_col), .wdata_i(lb1_rd),
    .raddr_i(cur_col), .rdata_o(lb2_rd));

  // Newest column comes straight from the line buffers and the input pixel.
  always_comb begin
    win    = '0;
    win[0] = pix_t'(top_q[0]);
    win[1] = pix_t'(top_q[1]);
    win[2] = pix_t'(lb2_rd);
    win[3] = pix_t'(mid_q[0]);
    win[4] = pix_t'(mid_q[1]);
    win[5] = pix_t'(lb1_rd);
    win[6] = pix_t'(bot_q[0]);
    win[7] = pix_t'(bot_q[1]);
    win[8] = pix_t'(s.in_pixel);
  end

  assign mag = GRAD_W'(sobel_mag(win));

  always_comb begin
    if (thr_en)                 res = (mag >= thr) ? '1 : '0;
    else if (|mag[GRAD_W-1:PIX_W]) res = '1;
    else                        res = mag[PIX_W-1:0];
  end

  always_comb begin
    vld_d = vld_q;
    pix_d = pix_q;
    sof_d = sof_q;
    eol_d = eol_q;
    if (accept) begin
      vld_d = interior;
      if (interior) begin
        pix_d = res;
        sof_d = (cur_row == RW'(2)) && (cur_col == CW'(2));
        eol_d = (cur_col == CW'(IMG_W-1));
      end
    end else if (s.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
      vld_q <= 1'b0;
      pix_q <= '0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept) begin
        top_q <= {lb2_rd, top_q[1]};
        mid_q <= {lb1_rd, mid_q[1]};
        bot_q <= {s.in_pixel, bot_q[1]};
      end
      vld_q <= vld_d;
      pix_q <= pix_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
    end
  end

  assign s.out_valid = vld_q;
  assign s.out_pixel = pix_q;
  assign s.out_sof   = sof_q;
  assign s.out_eol   = eol_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 frame: vector table plus stall,
// frame-restart and mid-frame reset sequences.
module tb_sobel_stream;
  localparam int IW = 8;
  localparam int IH = 6;

  typedef struct packed { logic [7:0] pix; logic sof; logic eol; } out_t;
  typedef struct { int pat; bit ten; int th; logic [5:0][7:0] line; } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic thr_en;
  logic [10:0] thr;
  int cmp = 0;
  int fails = 0;
  logic [7:0] img [IH][IW];
  out_t outq[$];
  out_t expq[$];
  vec_t vecs[6];

  sobel_stream_if #(.PIX_W(8)) bus();

  sobel_stream #(.PIX_W(8), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst_n(rst_n), .thr_en(thr_en), .thr(thr), .s(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int pat, input bit ten, input int th,
                              input int a, b, c, d, e, f);
    vec_t v;
    v.pat = pat; v.ten = ten; v.th = th;
    v.line[0] = 8'(a); v.line[1] = 8'(b); v.line[2] = 8'(c);
    v.line[3] = 8'(d); v.line[4] = 8'(e); v.line[5] = 8'(f);
    return v;
  endfunction

  task automatic fill_img(input int pat);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        case (pat)
          0: img[r][c] = 8'd100;
          1: img[r][c] = (c >= 4) ? 8'd255 : 8'd0;
          2: img[r][c] = 8'(10 * c);
          3: img[r][c] = 8'(20 * r);
          default: img[r][c] = 8'((r * 37 + c * 53 + r * c * 11) % 256);
        endcase
  endtask

  // Frame-level reference: direct convolution on the stored image.
  task automatic build_ref(input bit ten, input int th);
    int gx, gy, m, v;
    expq.delete();
    for (int r = 2; r < IH; r++)
      for (int c = 2; c < IW; c++) begin
        gx = (int'(img[r-2][c]) - int'(img[r-2][c-2])) + 2 * (int'(img[r-1][c]) - int'(img[r-1][c-2]))
           + (int'(img[r][c]) - int'(img[r][c-2]));
        gy = (int'(img[r-2][c-2]) - int'(img[r][c-2])) + 2 * (int'(img[r-2][c-1]) - int'(img[r][c-1]))
           + (int'(img[r-2][c]) - int'(img[r][c]));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (ten) v = (m >= th) ? 255 : 0;
        else     v = (m > 255) ? 255 : m;
        expq.push_back('{pix: 8'(v), sof: (r == 2 && c == 2), eol: (c == IW - 1)});
      end
  endtask

  task automatic compare(input string name);
    cmp++;
    if (outq.size() != expq.size()) begin
      fails++;
      $display("FAIL %s count: got %0d outputs, expected %0d", name, outq.size(), expq.size());
    end
    for (int i = 0; i < outq.size() && i < expq.size(); i++) begin
      cmp++;
      if (outq[i] !== expq[i]) begin
        fails++;
        $display("FAIL %s out[%0d]: got pix=%0d sof=%0b eol=%0b, expected pix=%0d sof=%0b eol=%0b",
                 name, i, outq[i].pix, outq[i].sof, outq[i].eol, expq[i].pix, expq[i].sof, expq[i].eol);
      end
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    cmp++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, got, want);
    end
  endtask

  task automatic sample();
    if (bus.out_valid && bus.out_ready)
      outq.push_back('{pix: bus.out_pixel, sof: bus.out_sof, eol: bus.out_eol});
  endtask

  // Send the first npix pixels of img in raster order, in_sof on the first.
  task automatic run(input int npix, input bit stall, input bit drain);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < npix && cyc < 4000) begin
      @(negedge clk);
      bus.in_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_pixel  = img[idx / IW][idx % IW];
      bus.in_sof    = (idx == 0);
      #1;
      sample();
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
    end
    cmp++;
    if (idx < npix) begin
      fails++;
      $display("FAIL run_timeout: sent %0d pixels, expected %0d", idx, npix);
    end
    if (drain)
      repeat (3) begin
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        sample();
      end
  endtask

  initial begin
    rst_n = 1'b0;
    thr_en = 1'b0;
    thr = '0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.in_sof = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset out_valid", bus.out_valid, 1'b0);
    check1("reset in_ready", bus.in_ready, 1'b1);
    check1("reset out_sof", bus.out_sof, 1'b0);
    check1("reset out_eol", bus.out_eol, 1'b0);
    cmp++;
    if (bus.out_pixel !== 8'd0) begin
      fails++;
      $display("FAIL reset out_pixel: got %0d, expected 0", bus.out_pixel);
    end
    rst_n = 1'b1;

    vecs[0] = mk(0, 1'b0, 0,    0, 0, 0, 0, 0, 0);
    vecs[1] = mk(1, 1'b0, 0,    0, 0, 255, 255, 0, 0);
    vecs[2] = mk(1, 1'b1, 1000, 0, 0, 255, 255, 0, 0);
    vecs[3] = mk(1, 1'b1, 1021, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(1, 1'b1, 1020, 0, 0, 255, 255, 0, 0);
    vecs[5] = mk(3, 1'b0, 0,    160, 160, 160, 160, 160, 160);

    for (int v = 0; v < 6; v++) begin
      fill_img(vecs[v].pat);
      thr_en = vecs[v].ten;
      thr = 11'(vecs[v].th);
      expq.delete();
      for (int i = 0; i < (IW - 2) * (IH - 2); i++)
        expq.push_back('{pix: vecs[v].line[i % 6], sof: (i == 0), eol: (i % 6 == 5)});
      outq.delete();
      run(IW * IH, 1'b0, 1'b1);
      compare($sformatf("vec%0d", v));
    end

    // Horizontal ramp, hand value: gx = 20+40+20 = 80.
    fill_img(2);
    thr_en = 1'b0;
    expq.delete();
    for (int i = 0; i < 24; i++) expq.push_back('{pix: 8'd80, sof: (i == 0), eol: (i % 6 == 5)});
    outq.delete();
    run(IW * IH, 1'b0, 1'b1);
    compare("hramp");

    // Textured frame: no-stall and randomly stalled runs against the reference.
    fill_img(4);
    build_ref(1'b0, 0);
    outq.delete();
    run(IW * IH, 1'b0, 1'b1);
    compare("tex_nostall");
    for (int k = 0; k < 3; k++) begin
      outq.delete();
      run(IW * IH, 1'b1, 1'b1);
      compare($sformatf("tex_stall%0d", k));
    end

    // Frame restart at pixel (3,5): partial frame yields 9 outputs, then a fresh frame.
    outq.delete();
    run(3 * IW + 5, 1'b0, 1'b1);
    cmp++;
    if (outq.size() != 9) begin
      fails++;
      $display("FAIL partial_count: got %0d outputs, expected 9", outq.size());
    end
    fill_img(3);
    build_ref(1'b0, 0);
    outq.delete();
    run(IW * IH, 1'b0, 1'b1);
    compare("restart");

    // Reset while an output is pending.
    fill_img(4);
    outq.delete();
    run(2 * IW + 4, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check1("pre_reset out_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("async_reset out_valid", bus.out_valid, 1'b0);
    check1("async_reset in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    fill_img(1);
    build_ref(1'b0, 0);
    outq.delete();
    run(IW * IH, 1'b0, 1'b1);
    compare("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel bit width (4..12).
REQ-002 SHALL have parameter IMG_W, default 640, meaning pixels per line (3..4096).
REQ-003 SHALL have parameter IMG_H, default 480, meaning lines per frame (3..4096).
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  input pixel valid.
REQ-007 SHALL have port in_ready  out  1  input pixel accepted when in_valid && in_ready.
REQ-008 SHALL have port in_pixel  in  PIX_W  unsigned pixel, raster order.
REQ-009 SHALL have port in_sof  in  1  marks first pixel (0,0) of a frame.
REQ-010 SHALL have port thr_en  in  1  0: magnitude output; 1: binary threshold output.
REQ-011 SHALL have port thr  in  PIX_W+3  threshold compared against unsaturated magnitude.
REQ-012 SHALL have port out_valid  out  1  output pixel valid.
REQ-013 SHALL have port out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-014 SHALL have port out_pixel  out  PIX_W  filtered pixel.
REQ-015 SHALL have port out_sof  out  1  marks first interior output pixel of a frame.
REQ-016 SHALL have port out_eol  out  1  marks last output pixel of an output line.

Function
REQ-017 SHALL track accepted-pixel column col (0..IMG_W-1) and row row (0..IMG_H-1); col wraps to 0 and row increments at col=IMG_W-1; row wraps to 0 after (IMG_W-1, IMG_H-1).
REQ-018 SHALL force col=0,row=0 for any accepted pixel with in_sof=1, including mid-frame (frame restart, partial frame discarded).
REQ-019 SHALL keep two line buffers of IMG_W entries holding rows row-1 and row-2, and a 3x3 window p0..p8 (p0 top-left, p4 centre, p8 bottom-right), shifted only on acceptance.
REQ-020 SHALL compute gx=(p2-p0)+2(p5-p3)+(p8-p6), gy=(p0-p6)+2(p1-p7)+(p2-p8) signed PIX_W+3 bits, mag=|gx|+|gy| unsigned PIX_W+3 bits, no overflow.
REQ-021 SHALL output, when thr_en=0, min(mag, 2^PIX_W-1); when thr_en=1, all-ones if mag>=thr else 0; thr_en/thr sampled on the accepting cycle.
REQ-022 SHALL produce exactly one output per accepted pixel with row>=2 and col>=2 (centre (row-1,col-1)); (IMG_W-2)*(IMG_H-2) outputs per frame; border pixels produce none.
REQ-023 SHALL present that output with out_valid=1 on the cycle after acceptance (latency 1).
REQ-024 SHALL assert out_sof with the output for row=2,col=2 and out_eol with outputs for col=IMG_W-1.
REQ-025 SHALL drive in_ready = !out_valid || out_ready (whole pipeline stalls on backpressure; no data loss or duplication).
REQ-026 SHALL hold out_pixel/out_sof/out_eol stable while out_valid && !out_ready.
REQ-027 SHALL, for an accepted pixel with row<2 or col<2, deassert out_valid on the next cycle once any pending output is taken.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear out_valid, out_pixel, out_sof, out_eol, col, row, and window registers to 0; in_ready=1 during and after reset.
REQ-029 SHALL not require line buffer RAM clearing; first frame after reset is correct because rows 0..1 produce no output.

Structure
REQ-030 SHALL place PIX_W-derived width constants (GRAD_W=PIX_W+3) and the gradient/magnitude function in shared package sobel_pkg.
REQ-031 SHALL implement line storage as sub-module sobel_linebuf (simple dual-port, IMG_W deep, PIX_W wide, read-before-write same address), instantiated twice.

Verification (IMG_W=8, IMG_H=6, PIX_W=8)
REQ-032 SHALL check: constant frame of 100, out_ready=1 -> 24 outputs all 0, out_sof on first, out_eol every 6th.
REQ-033 SHALL check: columns 0-3=0, 4-7=255, thr_en=0 -> each output line 0,0,255,255,0,0 (mag 1020 saturated).
REQ-034 SHALL check: same frame, thr_en=1, thr=1000 -> 0,0,255,255,0,0; thr=1021 -> all 0.
REQ-035 SHALL check: random out_ready (50%) with random in_valid -> output sequence identical to no-stall run, no drops or repeats.
REQ-036 SHALL check: in_sof asserted at pixel (3,5) of frame 1 -> counters restart, next 24 outputs match fresh-frame reference.
REQ-037 SHALL check: rst_n low mid-frame while out_valid=1 -> out_valid=0 immediately, next frame outputs correct.
